// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped GPIO block: IO region select bit and register offsets.
package mmio_pkg;

   localparam int IO_SEL_BIT = 13;

   localparam logic [3:0] OFF_BTN_STATE = 4'd0;
   localparam logic [3:0] OFF_LED       = 4'd1;
   localparam logic [3:0] OFF_BTN_EDGE  = 4'd2;
   localparam logic [3:0] OFF_CYCLES    = 4'd3;

   function automatic logic io_hit(input logic [15:0] addr);
      return addr[IO_SEL_BIT];
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, then either a stability-window debouncer
// (MMIO_GPIO_DEBOUNCE_EN defined) or a single extra register stage.
module btn_debounce #(
   parameter logic [15:0] DEB_CYC = 16'd50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic state,
   output logic rise
);

   logic sync1, sync2, state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

`ifdef MMIO_GPIO_DEBOUNCE_EN
   logic [15:0] cnt, cnt_nxt;

   // State only follows the synchronized input after DEB_CYC consecutive disagreeing cycles.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      if (sync2 != state) begin
         if (cnt == DEB_CYC - 16'd1) state_nxt = sync2;
         else                        cnt_nxt   = cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt_nxt;
   end
`else
   logic unused_deb;
   assign unused_deb = ^DEB_CYC;
   assign state_nxt  = sync2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= 1'b0;
      else        state <= state_nxt;
   end

   // Pulses in the cycle whose edge moves state 0->1, so the edge flag lands with the state.
   assign rise = state_nxt & ~state;

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: RAM pass-through below the IO bit, LED/button/cycle registers above it.
// Optional debounce filter enabled by defining MMIO_GPIO_DEBOUNCE_EN.
module mmio_gpio
   import mmio_pkg::*;
#(
   parameter int          DATA_W  = 16,
   parameter int          N_BTN   = 1,
   parameter int          N_LED   = 1,
   parameter logic [15:0] DEB_CYC = 16'd50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       address,
   input  logic              load,
   input  logic [DATA_W-1:0] in,
   output logic [DATA_W-1:0] out,
   output logic              ram_load,
   input  logic [DATA_W-1:0] ram_out,
   input  logic [N_BTN-1:0]  btn,
   output logic [N_LED-1:0]  led
);

   logic              io_sel, io_wr;
   logic [3:0]        off;
   logic [N_BTN-1:0]  btn_state, btn_rise, btn_edge, edge_clr;
   logic [N_LED-1:0]  led_reg;
   logic [DATA_W-1:0] cycles, io_rd;
   logic              unused_addr;

   assign io_sel      = io_hit(address);
   assign off         = address[3:0];
   assign io_wr       = load & io_sel;
   assign ram_load    = load & ~io_sel;
   assign unused_addr = ^{address[15:14], address[12:4]};

   for (genvar g = 0; g < N_BTN; g++) begin : gen_btn
      btn_debounce #(.DEB_CYC(DEB_CYC)) u_btn (
         .clk   (clk),
         .rst_n (rst_n),
         .btn   (btn[g]),
         .state (btn_state[g]),
         .rise  (btn_rise[g])
      );
   end

   assign edge_clr = (io_wr && off == OFF_BTN_EDGE) ? in[N_BTN-1:0] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_reg  <= '0;
         btn_edge <= '0;
         cycles   <= '0;
      end else begin
         if (io_wr && off == OFF_LED) led_reg <= in[N_LED-1:0];
         // A set in the same cycle as a clear keeps the flag.
         btn_edge <= (btn_edge & ~edge_clr) | btn_rise;
         cycles   <= (io_wr && off == OFF_CYCLES) ? in : cycles + 1'b1;
      end
   end

   assign led = led_reg;

   always_comb begin
      io_rd = '0;
      case (off)
         OFF_BTN_STATE: io_rd[N_BTN-1:0] = btn_state;
         OFF_LED:       io_rd[N_LED-1:0] = led_reg;
         OFF_BTN_EDGE:  io_rd[N_BTN-1:0] = btn_edge;
         OFF_CYCLES:    io_rd            = cycles;
         default:       io_rd            = '0;
      endcase
   end

   assign out = io_sel ? io_rd : ram_out;

endmodule

// File: tb/tb_mmio_gpio.sv
// Bench for mmio_gpio: directed scenarios plus random traffic against a behavioural model.
module tb_mmio_gpio;

   localparam int          DW = 16;
   localparam int          NB = 2;
   localparam int          NL = 4;
   localparam logic [15:0] DC = 16'd4;
`ifdef MMIO_GPIO_DEBOUNCE_EN
   localparam int RISE_N = 2 + int'(DC);
`else
   localparam int RISE_N = 3;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [15:0]   address;
   logic          load;
   logic [DW-1:0] din, out, ram_out;
   logic          ram_load;
   logic [NB-1:0] btn;
   logic [NL-1:0] led;

   int total = 0;
   int bad   = 0;

   mmio_gpio #(.DATA_W(DW), .N_BTN(NB), .N_LED(NL), .DEB_CYC(DC)) dut (
      .clk(clk), .rst_n(rst_n), .address(address), .load(load), .in(din),
      .out(out), .ram_load(ram_load), .ram_out(ram_out), .btn(btn), .led(led)
   );

   always #5 clk = ~clk;

   // model: register values as they stand after the most recent clock edge
   logic [NL-1:0] m_led;
   logic [15:0]   m_cyc;
   logic [NB-1:0] m_state, m_edge;
   int            run [NB];
   logic [NB-1:0] hist [$];

   function automatic void m_reset();
      m_led = '0; m_cyc = '0; m_state = '0; m_edge = '0;
      for (int i = 0; i < NB; i++) run[i] = 0;
      hist.delete();
   endfunction

   function automatic logic [NB-1:0] hist_back(input int k);
      if (hist.size() > k) return hist[hist.size() - 1 - k];
      return '0;
   endfunction

   function automatic void m_step();
      logic [NB-1:0] sync, nst, rise;
      hist.push_back(btn);
      if (hist.size() > 8) void'(hist.pop_front());
      sync = hist_back(2);
`ifdef MMIO_GPIO_DEBOUNCE_EN
      nst = m_state;
      for (int i = 0; i < NB; i++) begin
         if (sync[i] != m_state[i]) begin
            run[i]++;
            if (run[i] == int'(DC)) begin nst[i] = sync[i]; run[i] = 0; end
         end else run[i] = 0;
      end
`else
      nst = sync;
`endif
      rise = nst & ~m_state;
      if (load && address[13]) begin
         if (address[3:0] == 4'd1) m_led = din[NL-1:0];
         if (address[3:0] == 4'd2) m_edge = m_edge & ~din[NB-1:0];
      end
      m_cyc   = (load && address[13] && address[3:0] == 4'd3) ? din : m_cyc + 16'd1;
      m_edge  = m_edge | rise;
      m_state = nst;
   endfunction

   function automatic logic [15:0] m_out(input logic [15:0] a);
      if (!a[13]) return ram_out;
      case (a[3:0])
         4'd0:    return {{(16-NB){1'b0}}, m_state};
         4'd1:    return {{(16-NL){1'b0}}, m_led};
         4'd2:    return {{(16-NB){1'b0}}, m_edge};
         4'd3:    return m_cyc;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // drive inputs away from the edge, then check every output against the model
   task automatic drive(input logic [15:0] a, input logic ld, input logic [15:0] d, input logic [NB-1:0] b);
      @(negedge clk);
      address = a; load = ld; din = d; btn = b; ram_out = 16'($urandom);
      #1;
      chk("ram_load", {15'b0, ram_load}, {15'b0, ld & ~a[13]});
      chk("out", out, m_out(a));
      chk("led", {{(16-NL){1'b0}}, led}, {{(16-NL){1'b0}}, m_led});
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) m_step();
   endtask

   logic [NB-1:0] rb;

   initial begin
      address = '0; load = 1'b0; din = '0; btn = '0; ram_out = '0; rb = '0;
      m_reset();
      #1 rst_n = 1'b0;
      #2 address = 16'h2001;
      #1 chk("rst_led", {12'b0, led}, 16'h0000);
      chk("rst_led_rd", out, 16'h0000);
      address = 16'h2003;
      #1 chk("rst_cycles", out, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // RAM-region write
      drive(16'h0005, 1'b1, 16'hBEEF, 2'b00);
      chk("ram_wr_strobe", {15'b0, ram_load}, 16'h0001);
      chk("ram_wr_out", out, ram_out);
      tick();
      drive(16'h0005, 1'b0, 16'h0000, 2'b00);
      chk("ram_rd", out, ram_out);
      chk("ram_led0", {12'b0, led}, 16'h0000);
      tick();

      // LED register
      drive(16'h2001, 1'b1, 16'hFFFA, 2'b00);
      chk("led_wr_noram", {15'b0, ram_load}, 16'h0000);
      tick();
      drive(16'h2001, 1'b0, 16'h0000, 2'b00);
      chk("led_val", {12'b0, led}, 16'h000A);
      chk("led_rd", out, 16'h000A);
      tick();

      // cycle counter load and wrap
      drive(16'h2003, 1'b1, 16'hFFFE, 2'b00);
      tick();
      drive(16'h2003, 1'b0, 16'h0000, 2'b00);
      chk("cyc_fffe", out, 16'hFFFE);
      tick();
      drive(16'h2003, 1'b0, 16'h0000, 2'b00);
      chk("cyc_ffff", out, 16'hFFFF);
      tick();
      drive(16'h2003, 1'b0, 16'h0000, 2'b00);
      chk("cyc_wrap", out, 16'h0000);
      tick();

      // short glitch, then a held press
      for (int i = 0; i < 2; i++) begin drive(16'h2000, 1'b0, 16'h0, 2'b01); tick(); end
      for (int i = 0; i < 8; i++) begin drive(16'h2000, 1'b0, 16'h0, 2'b00); tick(); end
`ifdef MMIO_GPIO_DEBOUNCE_EN
      drive(16'h2000, 1'b0, 16'h0, 2'b00);
      chk("glitch_state", out, 16'h0000);
      tick();
      drive(16'h2002, 1'b0, 16'h0, 2'b00);
      chk("glitch_edge", out, 16'h0000);
      tick();
`endif
      drive(16'h2002, 1'b1, 16'h0003, 2'b00);
      tick();
      for (int i = 0; i < 10; i++) begin drive(16'h2000, 1'b0, 16'h0, 2'b01); tick(); end
      drive(16'h2000, 1'b0, 16'h0, 2'b01);
      chk("press_state", out & 16'h0001, 16'h0001);
      tick();
      drive(16'h2002, 1'b0, 16'h0, 2'b01);
      chk("press_edge", out & 16'h0001, 16'h0001);
      tick();
      for (int i = 0; i < 10; i++) begin drive(16'h2000, 1'b0, 16'h0, 2'b00); tick(); end

      // set and clear collide on the same edge
      drive(16'h2002, 1'b1, 16'h0003, 2'b00);
      tick();
      for (int i = 1; i <= RISE_N; i++) begin
         drive(16'h2002, (i == RISE_N), 16'h0001, 2'b01);
         tick();
      end
      drive(16'h2002, 1'b0, 16'h0, 2'b01);
      chk("set_wins", out & 16'h0001, 16'h0001);
      tick();
      drive(16'h2002, 1'b1, 16'h0001, 2'b01);
      tick();
      drive(16'h2002, 1'b0, 16'h0, 2'b01);
      chk("clear_only", out & 16'h0001, 16'h0000);
      tick();
      for (int i = 0; i < 10; i++) begin drive(16'h2000, 1'b0, 16'h0, 2'b00); tick(); end

      // random traffic
      for (int n = 0; n < 400; n++) begin
         logic [15:0] a;
         int r;
         r = int'($urandom_range(0, 7));
         if (r < 4)       a = 16'h2000 | 16'(r);
         else if (r == 4) a = 16'h2000 | 16'($urandom_range(4, 15));
         else if (r == 5) a = 16'($urandom) & 16'hDFFF;
         else             a = 16'h2000 | 16'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) rb[$urandom_range(0, NB-1)] ^= 1'b1;
         drive(a, ($urandom_range(0, 2) == 0), 16'($urandom), rb);
         tick();
      end

      // asynchronous reset between edges
      drive(16'h2001, 1'b1, 16'h0005, rb);
      tick();
      @(negedge clk);
      #2 rst_n = 1'b0;
      m_reset();
      load = 1'b0;
      #1 chk("arst_led", {12'b0, led}, 16'h0000);
      for (int o = 0; o < 4; o++) begin
         address = 16'h2000 | 16'(o);
         #1 chk("arst_io", out, 16'h0000);
      end
      address = 16'h200F;
      #1 chk("arst_unmapped", out, 16'h0000);
      @(negedge clk);
      btn = '0; rb = '0;
      rst_n = 1'b1;
      tick();
      drive(16'h200F, 1'b1, 16'hFFFF, 2'b00);
      tick();
      drive(16'h200F, 1'b0, 16'h0, 2'b00);
      chk("unmapped_rd", out, 16'h0000);
      tick();

      for (int n = 0; n < 100; n++) begin
         if ($urandom_range(0, 9) == 0) rb[$urandom_range(0, NB-1)] ^= 1'b1;
         drive(16'h2000 | 16'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0), 16'($urandom), rb);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmio_gpio.md
MMIO_GPIO -- requirements
Module: mmio_gpio

Interface
REQ-001 Parameter DATA_W, default 16: data bus width in bits.
REQ-002 Parameter N_BTN, default 1, range 1..DATA_W: number of button inputs.
REQ-003 Parameter N_LED, default 1, range 1..DATA_W: number of LED outputs.
REQ-004 Parameter DEB_CYC, default 16'd50000: debounce stability window in clk cycles, minimum 2.
REQ-005 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous assertion, active-low.
REQ-007 Port address, input, 16: CPU address; bit 13 selects the IO region, bits 3:0 select the IO register.
REQ-008 Port load, input, 1: CPU write strobe for the current address.
REQ-009 Port in, input, DATA_W: CPU write data.
REQ-010 Port out, output, DATA_W: CPU read data.
REQ-011 Port ram_load, output, 1: write strobe to the external RAM.
REQ-012 Port ram_out, input, DATA_W: read data from the external RAM.
REQ-013 Port btn, input, N_BTN: raw asynchronous button inputs, active-high.
REQ-014 Port led, output, N_LED: LED drive outputs, active-high.

Function
REQ-015 ram_load SHALL equal load AND NOT address[13], combinationally.
REQ-016 When address[13]=0, out SHALL equal ram_out combinationally.
REQ-017 When address[13]=1, out SHALL be selected combinationally by address[3:0]:
- 0 BTN_STATE: debounced button vector.
- 1 LED_REG: the LED register.
- 2 BTN_EDGE: the sticky rising-edge flags.
- 3 CYCLES: the cycle counter.
- Any other offset: zero.
REQ-018 Register fields narrower than DATA_W SHALL read zero-extended.
REQ-019 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-020 Writes with load=1 and address[13]=1 SHALL take effect on the next clk edge:
- LED_REG: loads in[N_LED-1:0].
- BTN_EDGE: each bit written 1 is cleared.
- CYCLES: loads in.
- BTN_STATE and unmapped offsets: ignored.
REQ-021 led SHALL equal LED_REG directly, with no additional latency.
REQ-022 A BTN_EDGE bit SHALL set for exactly one debounced 0->1 transition of its button; bits are sticky until cleared.
REQ-023 If a set event and a write-1-clear hit the same BTN_EDGE bit in the same cycle, set SHALL win.
REQ-024 CYCLES SHALL be a DATA_W-bit free-running counter that increments every cycle and wraps from all-ones to zero.
REQ-025 A CYCLES write SHALL override the increment in that cycle; the counter reads the written value on the following cycle.

Reset
REQ-026 While rst_n=0, the following SHALL be zero asynchronously: LED_REG (so led=0), BTN_STATE, BTN_EDGE, CYCLES, synchronizer flops and debounce counters.
REQ-027 No BTN_EDGE bit SHALL set because of the reset release itself.

Configuration
REQ-028 With MMIO_GPIO_DEBOUNCE_EN defined, each button SHALL have its own counter:
- The counter increments while the synchronized input differs from BTN_STATE, and resets to 0 when they match.
- On reaching DEB_CYC-1, BTN_STATE for that button takes the synchronized value and the counter resets.
REQ-029 Without MMIO_GPIO_DEBOUNCE_EN, BTN_STATE SHALL be the synchronized value registered once more (3 cycles from btn to BTN_STATE), and DEB_CYC SHALL be unused.

Structure
REQ-030 A shared package mmio_pkg SHALL hold:
- The IO register offsets: OFF_BTN_STATE=0, OFF_LED=1, OFF_BTN_EDGE=2, OFF_CYCLES=3.
- The IO select bit index IO_SEL_BIT=13.
REQ-031 A sub-module btn_debounce SHALL contain the synchronizer and debounce logic for one button, instantiated N_BTN times via generate.

Verification
REQ-032 Scenario: reset released, write address=16'h0005 in=16'hBEEF -> ram_load=1 that cycle; reading 16'h0005 returns ram_out; led stays 0.
REQ-033 Scenario: N_LED=4, write 16'h2001 in=16'hFFFA -> led=4'hA on the next cycle; reading 16'h2001 returns 16'h000A; ram_load stays 0.
REQ-034 Scenario: DEB_CYC=4 with debounce enabled, btn[0] glitches high for 2 cycles -> BTN_STATE and BTN_EDGE remain 0. btn[0] then held high for 10 cycles -> BTN_STATE[0]=1 and BTN_EDGE[0]=1.
REQ-035 Scenario: a BTN_EDGE[0] set and a write 16'h2002 in=16'h0001 occur in the same cycle -> bit remains 1. A later clear-only write -> reads 0.
REQ-036 Scenario: write 16'h2003 in=16'hFFFE -> reads 16'hFFFE, then 16'hFFFF, then 16'h0000 on successive cycles.
REQ-037 Scenario: rst_n asserted mid-run between clk edges -> led, out for IO offsets 0-3, and CYCLES read 0 immediately. Reading 16'h200F returns 0.
